// File: rtl/main_button_pkg.sv
// Shared constants and helpers for the push-button input port.
package main_button_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

   // Bits needed to count 0..cycles-1; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles < 32'd2) ? 32'd1 : 32'($clog2(cycles));
   endfunction

endpackage

// File: rtl/main_button_debounce.sv
// Single-line two-flop synchroniser followed by a hold-time debounce counter.
module main_button_debounce
   import main_button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter logic        INIT_BIT        = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic stable
);

   localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= INIT_BIT;
         sync <= INIT_BIT;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // Accept the new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         stable <= INIT_BIT;
      end else if (sync == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         stable <= sync;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/main_button_input.sv
// Avalon-MM button/switch input port: debounced data, edge capture with W1C, maskable irq.
module main_button_input
   import main_button_pkg::*;
#(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 500000,
   parameter int unsigned      EDGE_TYPE       = EDGE_FALLING,
   parameter logic [WIDTH-1:0] INIT_LEVEL      = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] d_prev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_db
      main_button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT_BIT        (INIT_LEVEL[i])
      ) u_db (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (in_port[i]),
         .stable  (d[i])
      );
   end

   assign wr_en        = chipselect & ~write_n;
   assign rise         = d & ~d_prev;
   assign fall         = ~d & d_prev;
   assign w1c          = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   always_comb begin
      ev = '0;
      case (EDGE_TYPE)
         EDGE_RISING: ev = rise;
         EDGE_ANY:    ev = rise | fall;
         default:     ev = fall;
      endcase
   end

   // A new edge wins over a same-cycle W1C on the same bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_prev       <= INIT_LEVEL;
         irq_mask     <= '0;
         edge_capture <= '0;
         irq          <= 1'b0;
      end else begin
         d_prev       <= d;
         edge_capture <= (edge_capture & ~w1c) | ev;
         irq          <= |(edge_capture & irq_mask);
         if (wr_en && (address == ADDR_MASK)) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: readdata = 32'(d);
         ADDR_MASK: readdata = 32'(irq_mask);
         ADDR_EDGE: readdata = 32'(edge_capture);
         default:   readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_main_button_input.sv
// Bench for main_button_input: windowed behavioural model plus directed literal checks.
module tb_main_button_input;

   localparam int       DB   = 4;
   localparam logic [3:0] INIT = 4'hF;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [1:0]  address    = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = 32'd0;
   logic [3:0]  in_port    = 4'hF;
   logic [31:0] readdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   main_button_input #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (1),
      .INIT_LEVEL      (4'hF)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial forever #5 clk = ~clk;

   // Model: raw input history; a bit's stable level flips once the synchronised input
   // (raw input two edges earlier) has differed for the last DB edges since the last flip/reset.
   logic [3:0]  hist [0:8191];
   int          n_m    = 0;
   int          lf [0:3];
   logic [3:0]  d_m    = 4'hF;
   logic [3:0]  mask_m = 4'h0;
   logic [3:0]  cap_m  = 4'h0;
   logic [3:0]  ev_m   = 4'h0;
   logic        irq_m  = 1'b0;
   logic [3:0]  init_v = INIT;
   logic [3:0]  clr_m;
   logic        all_diff;
   logic        s_bit;
   int          m_idx;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         n_m    = 0;
         d_m    = init_v;
         mask_m = 4'h0;
         cap_m  = 4'h0;
         ev_m   = 4'h0;
         irq_m  = 1'b0;
         for (int b = 0; b < 4; b++) lf[b] = 0;
      end else begin
         n_m       = n_m + 1;
         hist[n_m] = in_port;
         irq_m     = |(cap_m & mask_m);
         clr_m     = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
         cap_m     = (cap_m & ~clr_m) | ev_m;
         if (chipselect && !write_n && address == 2'd2) mask_m = writedata[3:0];
         ev_m = 4'h0;
         for (int b = 0; b < 4; b++) begin
            if (n_m - lf[b] >= DB) begin
               all_diff = 1'b1;
               for (int k = 0; k < DB; k++) begin
                  m_idx = n_m - k;
                  s_bit = (m_idx >= 3) ? hist[m_idx-2][b] : init_v[b];
                  if (s_bit == d_m[b]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  d_m[b] = ~d_m[b];
                  lf[b]  = n_m;
                  if (d_m[b] == 1'b0) ev_m[b] = 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   logic [31:0] exp_rd;
   initial forever begin
      @(negedge clk);
      case (address)
         2'd0:    exp_rd = {28'd0, d_m};
         2'd2:    exp_rd = {28'd0, mask_m};
         2'd3:    exp_rd = {28'd0, cap_m};
         default: exp_rd = 32'd0;
      endcase
      checks++;
      if (readdata !== exp_rd) begin
         errors++;
         $display("FAIL model_readdata addr=%0d got %h expected %h at %0t", address, readdata, exp_rd, $time);
      end
      checks++;
      if (irq !== irq_m) begin
         errors++;
         $display("FAIL model_irq got %b expected %b at %0t", irq, irq_m, $time);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(name, readdata, exp);
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] data);
      address    = a;
      writedata  = data;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   int idx;

   initial begin
      step(3);
      reset_n = 1'b1;
      step(1);
      rd_chk("rst_data", 2'd0, 32'hF);
      rd_chk("rst_mask", 2'd2, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      step(1);
      rd_chk("rst_edge", 2'd3, 32'h0);
      step(1);

      // Clean falling edge on bit 0: data after 6 edges, capture one edge later.
      in_port = 4'hE;
      address = 2'd0;
      step(5);
      rd_chk("lat_before", 2'd0, 32'hF);
      step(1);
      rd_chk("lat_data", 2'd0, 32'hE);
      rd_chk("lat_edge_pre", 2'd3, 32'h0);
      step(1);
      rd_chk("lat_edge", 2'd3, 32'h1);
      chk("irq_masked", {31'd0, irq}, 32'd0);
      step(1);
      chk("irq_masked2", {31'd0, irq}, 32'd0);

      bus_wr(2'd3, 32'h1);
      in_port = 4'hF;
      step(8);
      rd_chk("rise_no_cap", 2'd3, 32'h0);

      // 3-cycle glitch on bit 1 must be rejected.
      in_port = 4'hD;
      step(3);
      in_port = 4'hF;
      step(8);
      rd_chk("glitch_data", 2'd0, 32'hF);
      rd_chk("glitch_edge", 2'd3, 32'h0);
      step(1);

      // Masked interrupt on bit 0, then W1C clear.
      bus_wr(2'd2, 32'h1);
      in_port = 4'hE;
      step(7);
      rd_chk("irq_cap", 2'd3, 32'h1);
      chk("irq_pre", {31'd0, irq}, 32'd0);
      step(1);
      chk("irq_set", {31'd0, irq}, 32'd1);
      bus_wr(2'd3, 32'h1);
      rd_chk("w1c_cap", 2'd3, 32'h0);
      step(1);
      chk("irq_clr", {31'd0, irq}, 32'd0);

      // W1C of bit 2 on the very edge its capture sets.
      in_port = 4'hA;
      step(6);
      bus_wr(2'd3, 32'h4);
      rd_chk("w1c_collide", 2'd3, 32'h4);

      // Reset in the middle of a debounce on bit 3.
      in_port = 4'hF;
      step(10);
      bus_wr(2'd2, 32'hF);
      step(2);
      chk("pre_rst_irq", {31'd0, irq}, 32'd1);
      in_port = 4'h7;
      step(4);
      reset_n = 1'b0;
      rd_chk("rst_mid_edge", 2'd3, 32'h0);
      chk("rst_mid_irq", {31'd0, irq}, 32'd0);
      rd_chk("rst_mid_data", 2'd0, 32'hF);
      in_port = 4'hF;
      step(2);
      reset_n = 1'b1;
      step(10);
      rd_chk("post_rst_edge", 2'd3, 32'h0);
      rd_chk("post_rst_mask", 2'd2, 32'h0);

      // Random traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            idx = int'($urandom_range(0, 3));
            in_port[idx] = ~in_port[idx];
         end
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 5) == 0);
         write_n    = ($urandom_range(0, 1) == 0);
         writedata  = $urandom;
         if (c == 1000) reset_n = 1'b0;
         if (c == 1002) reset_n = 1'b1;
         step(1);
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
